phase_ctrl: RTL and testbench
=============================

PHASE_CTRL -- requirements
Module: phase_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16 (range 2..255): maximum number of memory wait cycles before an error.
REQ-002 SHALL have parameter AUTO_RUN, default 0: when 1, the block leaves IDLE on the first clock after reset without waiting for run.
REQ-003 SHALL have these ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- run  in  1  start/continue request
- mem_ready  in  1  memory completes the current access
- opcode  in  7  ir[6:0]
- funct3  in  3  ir[14:12]
- addr  in  2  low bits of the data address
- br_taken  in  1  branch condition result from the ALU
- cstate  out  4  one-hot phase {WB,EX,DE,IF}; 0000 in IDLE/HALT
- pc_sel  out  1  0 = pc+4, 1 = ALU target
- pc_ld  out  1  PC write strobe
- mem_sel  out  1  0 = PC address, 1 = data address
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_wrbits  out  4  byte write mask
- ir_ld  out  1  IR write strobe
- a_ld  out  1  A register write strobe
- b_ld  out  1  B register write strobe
- c_ld  out  1  C register write strobe
- rd_ld  out  1  register-file write strobe
- halted  out  1  block is in HALT
- err  out  1  sticky error flag

Function
REQ-004 SHALL implement the states IDLE, IF, DE, EX, WB, HALT; all outputs are registered or decoded from state only, with no combinational path from mem_ready to cstate.
REQ-005 IDLE SHALL go to IF when run=1 (or, with AUTO_RUN=1, on the first cycle after reset).
REQ-006 In IF the block SHALL drive mem_read=1 and mem_sel=0, and hold in IF until mem_ready=1; in that cycle it SHALL pulse ir_ld=1, then go to DE.
REQ-007 DE SHALL last exactly 1 cycle with a_ld=b_ld=1; EX SHALL last exactly 1 cycle with c_ld=1.
REQ-008 In WB, for load (0000011) and store (0100011), the block SHALL drive mem_sel=1 and mem_read=1, with mem_write=1 for store, and hold until mem_ready=1.
- All other opcodes complete WB in 1 cycle.
REQ-009 In the WB completion cycle the block SHALL pulse pc_ld=1 and SHALL pulse rd_ld=1 for opcodes 0010011, 0110011, 0110111, 0010111, 0000011, 1101111, 1100111.
REQ-010 pc_sel SHALL be 1 in WB for JAL/JALR, br_taken for branches (1100011), and 0 otherwise.
REQ-011 mem_wrbits SHALL take these values for stores:
- SB: 0001 << addr
- SH: 0011 for addr=00, 1100 for addr=10
- SW: 1111 for addr=00
- Misaligned SH/SW: mask 0000, mem_write=0, instruction still completes.
REQ-012 After WB completes, the block SHALL go to IF if run=1, else to IDLE; an instruction in flight always finishes.
REQ-013 A wait counter SHALL clear on entry to any wait phase and increment per cycle with mem_ready=0.
- When it reaches TIMEOUT: go to HALT, set err=1, no strobes issued.
- A mem_ready arriving in the same cycle the counter reaches TIMEOUT wins.
REQ-014 HALT SHALL be exited only by reset; halted=1 and all strobes are 0 in HALT.

Reset
REQ-015 Reset low SHALL asynchronously force state IDLE, counter 0, err=0, and all outputs 0, including mid-wait; after release, IF begins no earlier than the first clock edge.

Configuration
REQ-016 With PHASE_CTRL_ILLEGAL_TRAP_EN defined, an opcode outside {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011} seen at DE SHALL go to HALT with err=1; without the macro it SHALL execute as a NOP (pc_ld only, no rd_ld).

Verification
REQ-017 Reset, run=1, mem_ready tied 1, ADDI -> cstate 0001,0010,0100,1000 on consecutive cycles; rd_ld=pc_ld=1 in WB; pc_sel=0.
REQ-018 SB with addr=10 and mem_ready delayed 3 cycles -> WB held 4 cycles with mem_write=1, mem_wrbits=0100, single pc_ld pulse.
REQ-019 BEQ with br_taken=1 then br_taken=0 -> pc_sel=1 and pc_sel=0 respectively in WB; rd_ld=0 in both.
REQ-020 TIMEOUT=4, mem_ready=0 in IF -> HALT after 4 wait cycles, err=1, halted=1, no ir_ld pulse; only reset recovers.
REQ-021 Opcode 0000000 -> HALT with err=1 when PHASE_CTRL_ILLEGAL_TRAP_EN is defined; NOP completing in 4 cycles without it.
REQ-022 Reset asserted mid-WB of a store -> mem_write drops immediately; IDLE held until run=1.

Source files
------------

// File: rtl/phase_ctrl.sv
// -----------------------------------------------------------------------------
// phase_ctrl -- multi-cycle instruction phase controller
//
// Sequences one instruction at a time through fetch (IF), decode (DE),
// execute (EX) and write-back (WB). It issues the register and memory strobes
// for each phase. IF, and WB of loads/stores, wait for mem_ready under a
// watchdog. If that watchdog expires, the block goes to HALT and stays there
// until reset.
//
// Parameters
//   TIMEOUT   (2..255) maximum number of memory wait cycles before HALT/err
//   AUTO_RUN  when 1, leave IDLE on the first clock after reset without run
//
// Optional build macro
//   PHASE_CTRL_ILLEGAL_TRAP_EN  when defined, an unknown opcode seen in DE
//                               halts with err=1. Otherwise it runs as a NOP
//                               (pc_ld only).
//
// Ports
//   clock       in   sole clock, rising edge
//   reset       in   asynchronous, active-low reset
//   run         in   start/continue request
//   mem_ready   in   memory completes the current access
//   opcode      in   ir[6:0]
//   funct3      in   ir[14:12]
//   addr        in   low two bits of the data address
//   br_taken    in   branch condition from the ALU
//   cstate      out  one-hot phase {WB,EX,DE,IF}; 0000 in IDLE/HALT
//   pc_sel      out  0 = pc+4, 1 = ALU target
//   pc_ld       out  PC write strobe
//   mem_sel     out  0 = PC address, 1 = data address
//   mem_read    out  memory read request
//   mem_write   out  memory write request
//   mem_wrbits  out  byte write mask
//   ir_ld       out  IR write strobe
//   a_ld        out  A register write strobe
//   b_ld        out  B register write strobe
//   c_ld        out  C register write strobe
//   rd_ld       out  register-file write strobe
//   halted      out  block is in HALT
//   err         out  sticky error flag
// -----------------------------------------------------------------------------
module phase_ctrl #(
   parameter int TIMEOUT  = 16,
   parameter int AUTO_RUN = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       run,
   input  logic       mem_ready,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [1:0] addr,
   input  logic       br_taken,
   output logic [3:0] cstate,
   output logic       pc_sel,
   output logic       pc_ld,
   output logic       mem_sel,
   output logic       mem_read,
   output logic       mem_write,
   output logic [3:0] mem_wrbits,
   output logic       ir_ld,
   output logic       a_ld,
   output logic       b_ld,
   output logic       c_ld,
   output logic       rd_ld,
   output logic       halted,
   output logic       err
);

   // Opcode map
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   // One-hot phase codes presented on cstate
   localparam logic [3:0] PH_NONE = 4'b0000;
   localparam logic [3:0] PH_IF   = 4'b0001;
   localparam logic [3:0] PH_DE   = 4'b0010;
   localparam logic [3:0] PH_EX   = 4'b0100;
   localparam logic [3:0] PH_WB   = 4'b1000;

   // The counter holds the number of wait cycles already spent. The wait
   // cycle that would bring it to TIMEOUT is the last allowed one.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_IF,
      S_DE,
      S_EX,
      S_WB,
      S_HALT
   } state_t;

   state_t     state_reg;
   logic [7:0] wait_cnt_reg;
   logic       err_reg;
   logic [3:0] cstate_reg;
   logic       halted_reg;
   logic       boot_reg;     // high only during the first cycle after reset

   // ------------------------------------------------------------------
   // Instruction decode (the IR is stable from DE through WB)
   // ------------------------------------------------------------------
   logic       is_load;
   logic       is_store;
   logic       is_mem;
   logic       is_jump;
   logic       is_branch;
   logic       writes_rd;
   logic [3:0] st_mask;
   logic       st_ok;
   logic       wb_done;

   always_comb begin
      is_load   = (opcode == OP_LOAD);
      is_store  = (opcode == OP_STORE);
      is_mem    = is_load | is_store;
      is_jump   = (opcode == OP_JAL) | (opcode == OP_JALR);
      is_branch = (opcode == OP_BRANCH);
      writes_rd = (opcode == OP_IMM)   | (opcode == OP_REG)  |
                  (opcode == OP_LUI)   | (opcode == OP_AUIPC) |
                  (opcode == OP_LOAD)  | (opcode == OP_JAL)   |
                  (opcode == OP_JALR);
   end

   // Store byte lanes. A misaligned halfword or word, or an unknown width,
   // gives an empty mask. An empty mask also suppresses mem_write.
   always_comb begin
      st_mask = 4'b0000;
      case (funct3)
         3'b000: st_mask = 4'b0001 << addr;
         3'b001: begin
            case (addr)
               2'b00:   st_mask = 4'b0011;
               2'b10:   st_mask = 4'b1100;
               default: st_mask = 4'b0000;
            endcase
         end
         3'b010:  st_mask = (addr == 2'b00) ? 4'b1111 : 4'b0000;
         default: st_mask = 4'b0000;
      endcase
   end

   assign st_ok   = (st_mask != 4'b0000);
   // Non-memory instructions finish WB in one cycle. Loads and stores
   // (even a suppressed misaligned store) wait for memory.
   assign wb_done = ~is_mem | mem_ready;

`ifdef PHASE_CTRL_ILLEGAL_TRAP_EN
   logic is_legal;
   assign is_legal = is_mem | is_jump | is_branch | writes_rd;
`endif

   // ------------------------------------------------------------------
   // Phase sequencer. The registered cstate/halted copies are loaded
   // together with the state, so they never depend on a same-cycle input.
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg    <= S_IDLE;
         wait_cnt_reg <= 8'd0;
         err_reg      <= 1'b0;
         cstate_reg   <= PH_NONE;
         halted_reg   <= 1'b0;
         boot_reg     <= 1'b1;
      end else begin
         boot_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (run || ((AUTO_RUN != 0) && boot_reg)) begin
                  state_reg    <= S_IF;
                  cstate_reg   <= PH_IF;
                  wait_cnt_reg <= 8'd0;
               end
            end

            S_IF: begin
               // mem_ready is tested first, so it wins over an expiring count
               if (mem_ready) begin
                  state_reg  <= S_DE;
                  cstate_reg <= PH_DE;
               end else if (wait_cnt_reg == WAIT_LAST) begin
                  state_reg    <= S_HALT;
                  cstate_reg   <= PH_NONE;
                  halted_reg   <= 1'b1;
                  err_reg      <= 1'b1;
                  wait_cnt_reg <= wait_cnt_reg + 8'd1;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 8'd1;
               end
            end

            S_DE: begin
`ifdef PHASE_CTRL_ILLEGAL_TRAP_EN
               if (!is_legal) begin
                  state_reg  <= S_HALT;
                  cstate_reg <= PH_NONE;
                  halted_reg <= 1'b1;
                  err_reg    <= 1'b1;
               end else
`endif
               begin
                  state_reg  <= S_EX;
                  cstate_reg <= PH_EX;
               end
            end

            S_EX: begin
               state_reg    <= S_WB;
               cstate_reg   <= PH_WB;
               wait_cnt_reg <= 8'd0;
            end

            S_WB: begin
               if (wb_done) begin
                  // An instruction in flight always completes; run only
                  // decides whether another one is fetched.
                  if (run) begin
                     state_reg    <= S_IF;
                     cstate_reg   <= PH_IF;
                     wait_cnt_reg <= 8'd0;
                  end else begin
                     state_reg  <= S_IDLE;
                     cstate_reg <= PH_NONE;
                  end
               end else if (wait_cnt_reg == WAIT_LAST) begin
                  state_reg    <= S_HALT;
                  cstate_reg   <= PH_NONE;
                  halted_reg   <= 1'b1;
                  err_reg      <= 1'b1;
                  wait_cnt_reg <= wait_cnt_reg + 8'd1;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 8'd1;
               end
            end

            default: begin
               // HALT: terminal until reset
               state_reg  <= S_HALT;
               cstate_reg <= PH_NONE;
               halted_reg <= 1'b1;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Strobes. These are decoded from the current state register. Only the
   // completion strobes (ir_ld, pc_ld, rd_ld) also look at mem_ready, so
   // that they land in the very cycle the memory access finishes. Nothing
   // here feeds back into the state register.
   // ------------------------------------------------------------------
   always_comb begin
      pc_sel     = 1'b0;
      pc_ld      = 1'b0;
      mem_sel    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_wrbits = 4'b0000;
      ir_ld      = 1'b0;
      a_ld       = 1'b0;
      b_ld       = 1'b0;
      c_ld       = 1'b0;
      rd_ld      = 1'b0;
      case (state_reg)
         S_IF: begin
            mem_read = 1'b1;
            ir_ld    = mem_ready;
         end
         S_DE: begin
            a_ld = 1'b1;
            b_ld = 1'b1;
         end
         S_EX: begin
            c_ld = 1'b1;
         end
         S_WB: begin
            mem_sel    = is_mem;
            mem_read   = is_mem;
            mem_write  = is_store & st_ok;
            mem_wrbits = is_store ? st_mask : 4'b0000;
            pc_sel     = is_jump | (is_branch & br_taken);
            pc_ld      = wb_done;
            rd_ld      = wb_done & writes_rd;
         end
         default: begin
         end
      endcase
   end

   assign cstate = cstate_reg;
   assign halted = halted_reg;
   assign err    = err_reg;

endmodule

// File: tb/tb_phase_ctrl.sv
// -----------------------------------------------------------------------------
// tb_phase_ctrl -- self-checking bench for phase_ctrl (TIMEOUT=4, AUTO_RUN=0)
//
// Each directed instruction is turned into a per-cycle list of expected
// outputs. The list is built from the phase rules: IF waits for a ready
// memory access, DE/EX last one cycle each, WB waits only for memory ops,
// and at most TIMEOUT wait cycles are allowed. A compare process checks the
// DUT against that list on every negative clock edge. Literal spot checks
// pin the expected waveforms from the verification scenarios.
// -----------------------------------------------------------------------------
module tb_phase_ctrl;

   localparam int TP = 4;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_ST    = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_BAD   = 7'b0000000;

   typedef struct packed {
      logic [3:0] cs;
      logic       pc_sel;
      logic       pc_ld;
      logic       mem_sel;
      logic       mem_read;
      logic       mem_write;
      logic [3:0] wrbits;
      logic       ir_ld;
      logic       a_ld;
      logic       b_ld;
      logic       c_ld;
      logic       rd_ld;
      logic       halted;
      logic       err;
   } outv_t;

   logic       clock;
   logic       reset;
   logic       run;
   logic       mem_ready;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [1:0] addr;
   logic       br_taken;
   logic [3:0] cstate;
   logic       pc_sel;
   logic       pc_ld;
   logic       mem_sel;
   logic       mem_read;
   logic       mem_write;
   logic [3:0] mem_wrbits;
   logic       ir_ld;
   logic       a_ld;
   logic       b_ld;
   logic       c_ld;
   logic       rd_ld;
   logic       halted;
   logic       err;

   phase_ctrl #(
      .TIMEOUT (TP),
      .AUTO_RUN(0)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .run       (run),
      .mem_ready (mem_ready),
      .opcode    (opcode),
      .funct3    (funct3),
      .addr      (addr),
      .br_taken  (br_taken),
      .cstate    (cstate),
      .pc_sel    (pc_sel),
      .pc_ld     (pc_ld),
      .mem_sel   (mem_sel),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_wrbits(mem_wrbits),
      .ir_ld     (ir_ld),
      .a_ld      (a_ld),
      .b_ld      (b_ld),
      .c_ld      (c_ld),
      .rd_ld     (rd_ld),
      .halted    (halted),
      .err       (err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int          tests = 0;
   int          fails = 0;
   int          pc_ld_cnt = 0;
   int          ir_ld_cnt = 0;
   logic [31:0] cs_hist = '0;      // last eight cstate values, newest in [3:0]
   outv_t       exp_q[$];

   // Values that step() applies right after the next rising edge
   logic       p_run = 1'b0;
   logic [6:0] p_op  = '0;
   logic [2:0] p_f3  = '0;
   logic [1:0] p_ad  = '0;
   logic       p_bt  = 1'b0;

   // ------------------------------------------------------------------
   // Reference rules
   // ------------------------------------------------------------------
   function automatic logic [3:0] exp_mask(input logic [2:0] f3, input logic [1:0] ad);
      int sz;
      int m;
      sz = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
      if (sz == 0) return 4'b0000;
      if ((int'(ad) % sz) != 0) return 4'b0000;
      m = ((1 << sz) - 1) << int'(ad);
      return m[3:0];
   endfunction

   function automatic logic exp_writes_rd(input logic [6:0] op);
      return op inside {OP_IMM, OP_REG, OP_LUI, OP_AUIPC, OP_LD, OP_JAL, OP_JALR};
   endfunction

   function automatic logic exp_legal(input logic [6:0] op);
      return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LD, OP_ST, OP_IMM, OP_REG};
   endfunction

   function automatic outv_t halt_v();
      outv_t e;
      e = '0;
      e.halted = 1'b1;
      e.err    = 1'b1;
      return e;
   endfunction

   // ------------------------------------------------------------------
   // Compare process: one check per cycle that has an expectation
   // ------------------------------------------------------------------
   initial begin
      outv_t a;
      outv_t e;
      forever begin
         @(negedge clock);
         a = {cstate, pc_sel, pc_ld, mem_sel, mem_read, mem_write, mem_wrbits,
              ir_ld, a_ld, b_ld, c_ld, rd_ld, halted, err};
         cs_hist = {cs_hist[27:0], cstate};
         if (pc_ld === 1'b1) pc_ld_cnt++;
         if (ir_ld === 1'b1) ir_ld_cnt++;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            tests++;
            if (a !== e) begin
               fails++;
               $display("FAIL cycle_outputs t=%0t: got %05h (cs=%b) expected %05h (cs=%b)",
                        $time, a, a.cs, e, e.cs);
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   // One clock cycle: drive inputs just after the edge, queue the expectation
   task automatic step(input logic mr, input outv_t e);
      @(posedge clock);
      #1;
      run       = p_run;
      mem_ready = mr;
      opcode    = p_op;
      funct3    = p_f3;
      addr      = p_ad;
      br_taken  = p_bt;
      exp_q.push_back(e);
   endtask

   task automatic settle();
      @(negedge clock);
      #1;
   endtask

   // Asynchronous reset in the middle of a cycle, then one full reset cycle
   task automatic reset_mid(input logic mw_before);
      outv_t e;
      e = '0;
      @(posedge clock);
      #1;
      p_run     = 1'b0;
      run       = 1'b0;
      mem_ready = 1'b0;
      exp_q.push_back(e);
      #1 check("pre_reset_mem_write", mem_write, mw_before);
      #1 reset = 1'b0;
      #1;
      check("reset_mem_write", mem_write, 0);
      check("reset_cstate", cstate, 0);
      check("reset_err", err, 0);
      check("reset_halted", halted, 0);
      step(1'b0, e);
      #2 reset = 1'b1;
   endtask

   // Idle with run=0 for two cycles, then raise run (IF follows next cycle)
   task automatic start_run();
      outv_t e;
      e = '0;
      p_run = 1'b0;
      step(1'b0, e);
      step(1'b0, e);
      p_run = 1'b1;
      step(1'b0, e);
   endtask

   // One instruction from IF onwards. The ready_* values give how many
   // cycles memory stalls before answering. rst_k >= 0 resets in that WB cycle.
   task automatic do_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input logic [1:0] ad, input logic bt, input int ready_if,
                           input int ready_wb, input logic run_after, input int rst_k);
      outv_t e;
      int    pc0;
      int    ir0;
      int    nwb;
      logic  is_st;
      logic  is_mem;
      logic  last;
      logic  mr;
      logic [3:0] mask;
      pc0    = pc_ld_cnt;
      ir0    = ir_ld_cnt;
      is_st  = (op == OP_ST);
      is_mem = (op == OP_LD) || is_st;
      mask   = is_st ? exp_mask(f3, ad) : 4'b0000;
      $display("[TB] %s op=%b f3=%0d addr=%0d br=%0d if_stall=%0d wb_stall=%0d",
               nm, op, f3, ad, bt, ready_if, ready_wb);
      p_op = op; p_f3 = f3; p_ad = ad; p_bt = bt; p_run = 1'b1;

      // Fetch: at most TP cycles in IF
      for (int k = 0; k < TP; k++) begin
         mr = (k == ready_if);
         e = '0; e.cs = 4'b0001; e.mem_read = 1'b1; e.ir_ld = mr;
         step(mr, e);
         if (mr) break;
      end
      if (ready_if >= TP) begin
         e = halt_v();
         step(1'b1, e);
         settle();
         check("timeout_trace", cs_hist[19:0], 20'h11110);
         check("timeout_no_ir_ld", ir_ld_cnt, ir0);
         for (int k = 0; k < 3; k++) step(1'b1, e);
         settle();
         check("timeout_halted", halted, 1);
         check("timeout_err", err, 1);
         return;
      end

      e = '0; e.cs = 4'b0010; e.a_ld = 1'b1; e.b_ld = 1'b1;
      step(1'b0, e);
`ifdef PHASE_CTRL_ILLEGAL_TRAP_EN
      if (!exp_legal(op)) begin
         e = halt_v();
         step(1'b0, e);
         step(1'b1, e);
         settle();
         check("trap_err", err, 1);
         check("trap_halted", halted, 1);
         return;
      end
`endif
      e = '0; e.cs = 4'b0100; e.c_ld = 1'b1;
      step(1'b0, e);

      nwb = is_mem ? ready_wb + 1 : 1;
      for (int k = 0; k < nwb; k++) begin
         if (k == rst_k) begin
            reset_mid(is_st && (mask != 4'b0000));
            return;
         end
         last = (k == nwb - 1);
         mr   = is_mem && last;
         if (last) p_run = run_after;
         e = '0;
         e.cs        = 4'b1000;
         e.mem_sel   = is_mem;
         e.mem_read  = is_mem;
         e.mem_write = is_st && (mask != 4'b0000);
         e.wrbits    = mask;
         e.pc_sel    = (op == OP_JAL || op == OP_JALR) ? 1'b1 : (op == OP_BR) ? bt : 1'b0;
         e.pc_ld     = last;
         e.rd_ld     = last && exp_writes_rd(op);
         step(mr, e);
      end
      settle();
      check({nm, " pc_ld_pulses"}, pc_ld_cnt - pc0, 1);
   endtask

   // ------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------
   initial begin
      outv_t e;
      e = '0;
      reset = 1'b0; run = 1'b0; mem_ready = 1'b0;
      opcode = '0; funct3 = '0; addr = '0; br_taken = 1'b0;

      step(1'b0, e);
      settle();
      check("reset_state_cstate", cstate, 0);
      check("reset_state_err", err, 0);
      step(1'b0, e);
      #2 reset = 1'b1;
      start_run();

      do_instr("ADDI", OP_IMM, 3'd0, 2'd0, 1'b0, 0, 0, 1'b1, -1);
      check("addi_phase_trace", cs_hist[15:0], 16'h1248);
      check("addi_rd_ld", rd_ld, 1);
      check("addi_pc_ld", pc_ld, 1);
      check("addi_pc_sel", pc_sel, 0);

      do_instr("SB a=2", OP_ST, 3'd0, 2'd2, 1'b0, 0, 3, 1'b1, -1);
      check("sb_wb_trace", cs_hist[19:0], 20'h48888);
      check("sb_wrbits", mem_wrbits, 4'b0100);
      check("sb_mem_write", mem_write, 1);

      do_instr("BEQ taken", OP_BR, 3'd0, 2'd0, 1'b1, 0, 0, 1'b1, -1);
      check("beq_taken_pc_sel", pc_sel, 1);
      check("beq_taken_rd_ld", rd_ld, 0);
      do_instr("BEQ not taken", OP_BR, 3'd0, 2'd0, 1'b0, 0, 0, 1'b1, -1);
      check("beq_nt_pc_sel", pc_sel, 0);
      check("beq_nt_rd_ld", rd_ld, 0);

      do_instr("SH a=2", OP_ST, 3'd1, 2'd2, 1'b0, 1, 0, 1'b1, -1);
      check("sh_wrbits", mem_wrbits, 4'b1100);
      do_instr("SH a=1 misaligned", OP_ST, 3'd1, 2'd1, 1'b0, 0, 1, 1'b1, -1);
      check("sh_mis_mem_write", mem_write, 0);
      do_instr("SW a=0", OP_ST, 3'd2, 2'd0, 1'b0, 0, 0, 1'b1, -1);
      do_instr("SW a=2 misaligned", OP_ST, 3'd2, 2'd2, 1'b0, 0, 2, 1'b1, -1);
      do_instr("SB a=3", OP_ST, 3'd0, 2'd3, 1'b0, 0, 0, 1'b1, -1);
      do_instr("LW late ready", OP_LD, 3'd2, 2'd0, 1'b0, TP - 1, TP - 1, 1'b0, -1);
      check("lw_last_wait_rd_ld", rd_ld, 1);

      start_run();
      do_instr("JAL", OP_JAL, 3'd0, 2'd0, 1'b0, 0, 0, 1'b1, -1);
      do_instr("JALR", OP_JALR, 3'd0, 2'd0, 1'b0, 0, 0, 1'b1, -1);
      do_instr("LUI", OP_LUI, 3'd0, 2'd0, 1'b1, 0, 0, 1'b1, -1);
      do_instr("AUIPC", OP_AUIPC, 3'd0, 2'd0, 1'b0, 0, 0, 1'b1, -1);
      do_instr("ADD", OP_REG, 3'd0, 2'd0, 1'b0, 2, 0, 1'b1, -1);

      do_instr("illegal 0000000", OP_BAD, 3'd0, 2'd0, 1'b0, 0, 0, 1'b0, -1);
`ifndef PHASE_CTRL_ILLEGAL_TRAP_EN
      check("nop_trace", cs_hist[15:0], 16'h1248);
      check("nop_rd_ld", rd_ld, 0);
      check("nop_err", err, 0);
`endif
      reset_mid(1'b0);
      start_run();

      do_instr("SW reset in WB", OP_ST, 3'd2, 2'd0, 1'b0, 0, 5, 1'b1, 1);
      start_run();

      do_instr("ADDI fetch timeout", OP_IMM, 3'd0, 2'd0, 1'b0, TP + 5, 0, 1'b1, -1);
      reset_mid(1'b0);
      start_run();
      do_instr("ADDI after recovery", OP_IMM, 3'd0, 2'd0, 1'b0, 0, 0, 1'b0, -1);
      e = '0;
      step(1'b0, e);
      step(1'b0, e);
      settle();

      check("expectations_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
